// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the delay-line record for the frame reader.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_ONE = 10'd1;

  localparam logic [CNT_W-1:0] H_VISIBLE = 10'd640;
  localparam logic [CNT_W-1:0] H_FP      = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC    = 10'd96;
  localparam logic [CNT_W-1:0] H_BP      = 10'd48;
  localparam logic [CNT_W-1:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam logic [CNT_W-1:0] V_VISIBLE = 10'd480;
  localparam logic [CNT_W-1:0] V_FP      = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC    = 10'd2;
  localparam logic [CNT_W-1:0] V_BP      = 10'd33;
  localparam logic [CNT_W-1:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [CNT_W-1:0] SCREEN_W = H_VISIBLE;
  localparam logic [CNT_W-1:0] SCREEN_H = V_VISIBLE;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic videoOn;
    logic inWindow;
  } alignT;

  // Idle value keeps syncs deasserted so a freshly reset delay line emits no spurious pulse.
  localparam alignT ALIGN_IDLE = '{hsync: 1'b1, vsync: 1'b1, videoOn: 1'b0, inWindow: 1'b0};

  function automatic logic dimsOk(input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] h);
    return (w != '0) && (h != '0) && (w <= SCREEN_W) && (h <= SCREEN_H);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 pixel/line counters with undelayed sync, visible and frame-start decode.
module vga_timing
  import vga_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] hCnt_o,
  output logic [CNT_W-1:0] vCnt_o,
  output logic             hsyncRaw_o,
  output logic             vsyncRaw_o,
  output logic             visibleRaw_o,
  output logic             frameStart_o,
  output logic             lastCycle_o
);

  logic [CNT_W-1:0] hCnt_q, hCnt_d;
  logic [CNT_W-1:0] vCnt_q, vCnt_d;
  logic             lineEnd;
  logic             lastLine;

  always_comb begin
    lineEnd  = (hCnt_q == H_TOTAL - CNT_ONE);
    lastLine = (vCnt_q == V_TOTAL - CNT_ONE);
    hCnt_d   = lineEnd ? '0 : hCnt_q + CNT_ONE;
    vCnt_d   = vCnt_q;
    if (lineEnd) begin
      vCnt_d = lastLine ? '0 : vCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  assign hCnt_o       = hCnt_q;
  assign vCnt_o       = vCnt_q;
  assign hsyncRaw_o   = !((hCnt_q >= H_SYNC_START) && (hCnt_q < H_SYNC_END));
  assign vsyncRaw_o   = !((vCnt_q >= V_SYNC_START) && (vCnt_q < V_SYNC_END));
  assign visibleRaw_o = (hCnt_q < H_VISIBLE) && (vCnt_q < V_VISIBLE);
  // Masked by reset so the pulse is only seen once the counters actually run from 0,0.
  assign frameStart_o = (hCnt_q == '0) && (vCnt_q == '0) && !rst_i;
  assign lastCycle_o  = lineEnd && lastLine;

endmodule

// File: rtl/vga_frame_reader.sv
// Display-side reader of the output frame RAM: centres the stored image in 640x480 and
// aligns pixel data with sync/blanking across the RAM read latency.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int          RAM_LATENCY  = 1,
  parameter logic [7:0]  BORDER_COLOR = 8'h00,
  parameter int          ADDR_W       = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_ready_i,
  input  logic [CNT_W-1:0]  img_width_i,
  input  logic [CNT_W-1:0]  img_height_i,
  input  logic [7:0]        ram_data_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        pixel_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              video_on_o,
  output logic              frame_start_o
);

  logic [CNT_W-1:0] hCnt, vCnt;
  logic             hsyncRaw, vsyncRaw, visibleRaw, lastCycle;

  vga_timing uTiming (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .hCnt_o       (hCnt),
    .vCnt_o       (vCnt),
    .hsyncRaw_o   (hsyncRaw),
    .vsyncRaw_o   (vsyncRaw),
    .visibleRaw_o (visibleRaw),
    .frameStart_o (frame_start_o),
    .lastCycle_o  (lastCycle)
  );

  logic [CNT_W-1:0]  width_q, height_q, x0_q, y0_q;
  logic [CNT_W-1:0]  x0_d, y0_d;
  logic              frameValid_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  alignT             rawAlign;
  alignT             dly_q [RAM_LATENCY];
  alignT             tail;
  logic [7:0]        pixel_q, pixel_d;
  logic              hsync_q, vsync_q, videoOn_q;

  always_comb begin
    x0_d = (SCREEN_W - img_width_i) >> 1;
    y0_d = (SCREEN_H - img_height_i) >> 1;
    rawAlign.hsync    = hsyncRaw;
    rawAlign.vsync    = vsyncRaw;
    rawAlign.videoOn  = visibleRaw;
    rawAlign.inWindow = frameValid_q
                        && (hCnt >= x0_q) && (hCnt < x0_q + width_q)
                        && (vCnt >= y0_q) && (vCnt < y0_q + height_q);
    addr_d = addr_q;
    if (lastCycle) begin
      addr_d = '0;
    end else if (rawAlign.inWindow) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Geometry is only sampled on the final cycle of a frame so an image never tears mid-scan.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_q      <= '0;
      height_q     <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      frameValid_q <= 1'b0;
      addr_q       <= '0;
    end else begin
      if (lastCycle) begin
        width_q      <= img_width_i;
        height_q     <= img_height_i;
        x0_q         <= x0_d;
        y0_q         <= y0_d;
        frameValid_q <= frame_ready_i && dimsOk(img_width_i, img_height_i);
      end
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RAM_LATENCY; i++) dly_q[i] <= ALIGN_IDLE;
    end else begin
      dly_q[0] <= rawAlign;
      for (int i = 1; i < RAM_LATENCY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign tail    = dly_q[RAM_LATENCY-1];
  assign pixel_d = (tail.videoOn && tail.inWindow) ? ram_data_i : BORDER_COLOR;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pixel_q   <= BORDER_COLOR;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      videoOn_q <= 1'b0;
    end else begin
      pixel_q   <= pixel_d;
      hsync_q   <= tail.hsync;
      vsync_q   <= tail.vsync;
      videoOn_q <= tail.videoOn;
    end
  end

  assign ram_addr_o = addr_q;
  assign pixel_o    = pixel_q;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign video_on_o = videoOn_q;

endmodule
